hazard_ctrl: RTL

//  Central stall/flush controller for the 5-stage pipeline; drives the hold input of the F/D register, PC enable and E-stage bubble.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/md_busy_seq.sv | 50 +++++
 rtl/hazard_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings, FSM type and default latencies for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] T_NONE = 2'd3;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2
  } md_state_t;

  // A source register of D conflicts with a producer when the producer writes it and the value
  // will not be ready by the time D needs it. $zero never conflicts.
  function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] wa, input logic [1:0] tnew);
    return (src != 5'd0) && (tuse != T_NONE) && (wa == src) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_seq.sv
// Mult/div busy sequencer: tracks HI/LO occupancy with a down-counter and pulses md_done
// in the final busy cycle. A new start is accepted when idle or in that final cycle.
module md_busy_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy,
  output logic md_done
);

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_busy = (state_q != StIdle);
    md_done = md_busy && (cnt_q == CNT_W'(1));
    load    = start && ((state_q == StIdle) || md_done);

    if (load) begin
      state_d = is_div ? StDiv : StMul;
      cnt_d   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (md_done) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (md_busy) begin
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side stall/flush controller: RAW Tuse/Tnew checks plus mult/div occupancy.
// Define HAZARD_STATS_EN to add saturating stall_cycles / md_stall_cycles counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_div,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles,
`endif
  output logic        stall_d,
  output logic        pc_en,
  output logic        flush_e,
  output logic        md_busy,
  output logic        md_done
);

  logic stall_rs, stall_rt, stall_md;

  md_busy_seq #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (e_md_start),
    .is_div  (e_md_div),
    .md_busy (md_busy),
    .md_done (md_done)
  );

  // Outputs are forced quiet while reset is held, even with hazardous inputs present.
  always_comb begin
    stall_rs = raw_hit(d_rs, d_tuse_rs, e_wa, e_tnew) | raw_hit(d_rs, d_tuse_rs, m_wa, m_tnew);
    stall_rt = raw_hit(d_rt, d_tuse_rt, e_wa, e_tnew) | raw_hit(d_rt, d_tuse_rt, m_wa, m_tnew);
    stall_md = reset & d_is_md & (md_busy | e_md_start);
    stall_d  = reset & (stall_rs | stall_rt | stall_md);
    pc_en    = ~stall_d;
    flush_e  = stall_d;
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_cnt_q, md_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    md_cnt_d    = md_cnt_q;
    if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (stall_md && (md_cnt_q != '1))   md_cnt_d    = md_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      md_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign md_stall_cycles = md_cnt_q;
`endif

endmodule
